// File: rtl/dm_responder_pkg.sv
// ----------------------------------------------------------------------------
// dm_responder_pkg
//    Shared definitions for the data-memory responder: FSM state encoding,
//    default geometry and a helper that sizes the byte window of the memory.
//
//    Optional feature macro used by the top level: DM_TRACE_EN.
// ----------------------------------------------------------------------------
package dm_responder_pkg;

   // Two-state controller: zero the array after reset, then serve the CPU.
   typedef enum logic {
      DM_CLEAR = 1'b0,
      DM_READY = 1'b1
   } dm_state_e;

   localparam logic [31:0] DM_DEFAULT_BASE  = 32'h0000_0000;
   localparam int          DM_DEFAULT_DEPTH = 3072;
   localparam int          DM_LANES         = 4;

   // Size in bytes of a DEPTH-word window, held in 33 bits so that a window
   // reaching the top of the 32-bit address space cannot overflow.
   function automatic logic [32:0] dm_span_bytes(input int depth);
      logic [32:0] span;
      span = 33'(depth) << 2;
      return span;
   endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// ----------------------------------------------------------------------------
// dm_byte_merge
//    Combinational byte-lane merge for a 32-bit word. Lane k of the result
//    comes from wdata_i when byteen_i[k] is set, otherwise from old_word_i.
//    Shared by the memory write path and the write trace so both always see
//    the same post-write word.
//
// Ports
//    old_word_i     in  32  current contents of the addressed word
//    wdata_i        in  32  lane-aligned store data
//    byteen_i       in   4  per-lane write enables
//    merged_word_o  out 32  word as it will look after the write
// ----------------------------------------------------------------------------
module dm_byte_merge
   import dm_responder_pkg::*;
(
   input  logic [31:0]         old_word_i,
   input  logic [31:0]         wdata_i,
   input  logic [DM_LANES-1:0] byteen_i,
   output logic [31:0]         merged_word_o
);

   for (genvar gi = 0; gi < DM_LANES; gi++) begin : g_lane
      assign merged_word_o[8*gi +: 8] = byteen_i[gi] ? wdata_i[8*gi +: 8]
                                                     : old_word_i[8*gi +: 8];
   end

endmodule

// File: rtl/dm_responder.sv
// ----------------------------------------------------------------------------
// dm_responder
//    Memory end of the CPU data port. Word reads are combinational; byte-
//    enabled writes commit on the rising clock edge. After reset the block
//    zeroes every word, one per cycle, and only then starts accepting CPU
//    accesses (dm_ready). Writes outside the window set a sticky error flag;
//    accepted writes are counted.
//
// Parameters
//    DEPTH   number of 32-bit words
//    BASE    byte address of word 0 (word-aligned)
//
// Ports
//    clk            in   1   clock, all state updates on posedge
//    reset          in   1   asynchronous, active-low reset
//    m_data_addr    in  32   byte address, bits [1:0] ignored
//    m_data_wdata   in  32   lane-aligned store data
//    m_data_byteen  in   4   per-byte write enables, 0 = read only
//    m_inst_addr    in  32   PC of the accessing instruction (trace only)
//    m_data_rdata   out 32   combinational read data
//    dm_ready       out  1   clear sequence finished
//    err_oob        out  1   sticky out-of-window write attempt
//    wr_count       out 32   number of accepted writes (wraps)
//
// Configuration
//    DM_TRACE_EN    when defined, every accepted write prints one trace line
//                   with the PC, word address and full post-write word.
// ----------------------------------------------------------------------------
module dm_responder
   import dm_responder_pkg::*;
#(
   parameter int          DEPTH = DM_DEFAULT_DEPTH,
   parameter logic [31:0] BASE  = DM_DEFAULT_BASE
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] m_data_addr,
   input  logic [31:0] m_data_wdata,
   input  logic [3:0]  m_data_byteen,
   input  logic [31:0] m_inst_addr,
   output logic [31:0] m_data_rdata,
   output logic        dm_ready,
   output logic        err_oob,
   output logic [31:0] wr_count
);

   localparam int               IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [32:0]      SPAN     = dm_span_bytes(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [31:0]      mem_q [DEPTH];
   dm_state_e        state_q,     state_d;
   logic [IDX_W-1:0] clr_ptr_q,   clr_ptr_d;
   logic             err_oob_q,   err_oob_d;
   logic [31:0]      wr_count_q,  wr_count_d;

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   // The subtraction is done in 33 bits so the borrow tells us directly
   // whether the address lies below BASE.
   logic [32:0]      addr_diff;
   logic [31:0]      offset;
   logic             in_range;
   logic [IDX_W-1:0] idx;

   assign addr_diff = {1'b0, m_data_addr} - {1'b0, BASE};
   assign offset    = addr_diff[31:0];
   assign in_range  = !addr_diff[32] && ({1'b0, offset} < SPAN);
   assign idx       = offset[IDX_W+1:2];

   // ------------------------------------------------------------------
   // Read and merge
   // ------------------------------------------------------------------
   logic [31:0] old_word;
   logic [31:0] merged_word;
   logic        is_ready;
   logic        wr_req;
   logic        wr_hit;
   logic        wr_oob;

   assign old_word = mem_q[idx];
   assign is_ready = (state_q == DM_READY);
   assign wr_req   = is_ready && (m_data_byteen != 4'b0000);
   assign wr_hit   = wr_req && in_range;
   assign wr_oob   = wr_req && !in_range;

   dm_byte_merge u_merge (
      .old_word_i    (old_word),
      .wdata_i       (m_data_wdata),
      .byteen_i      (m_data_byteen),
      .merged_word_o (merged_word)
   );

   // The array is read before the edge, so a same-cycle write to the word
   // being read still returns the old contents.
   assign m_data_rdata = (is_ready && in_range) ? old_word : 32'h0;

   // ------------------------------------------------------------------
   // Single memory write port, shared by the clear sequence and the CPU
   // ------------------------------------------------------------------
   logic             mem_we;
   logic [IDX_W-1:0] mem_waddr;
   logic [31:0]      mem_wdata;

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = clr_ptr_q;
      mem_wdata = 32'h0;
      if (state_q == DM_CLEAR) begin
         mem_we    = 1'b1;
         mem_waddr = clr_ptr_q;
         mem_wdata = 32'h0;
      end else if (wr_hit) begin
         mem_we    = 1'b1;
         mem_waddr = idx;
         mem_wdata = merged_word;
      end
   end

   // No reset on the array itself: the clear sequence zeroes it instead.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // ------------------------------------------------------------------
   // Controller: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      clr_ptr_d  = clr_ptr_q;
      err_oob_d  = err_oob_q;
      wr_count_d = wr_count_q;
      case (state_q)
         DM_CLEAR: begin
            // CPU traffic is ignored entirely while clearing.
            if (clr_ptr_q == LAST_IDX) begin
               clr_ptr_d = '0;
               state_d   = DM_READY;
            end else begin
               clr_ptr_d = clr_ptr_q + 1'b1;
            end
         end
         DM_READY: begin
            if (wr_hit) begin
               wr_count_d = wr_count_q + 32'd1;
            end
            if (wr_oob) begin
               err_oob_d = 1'b1;
            end
         end
         default: begin
            state_d = DM_CLEAR;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Controller: state registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= DM_CLEAR;
         clr_ptr_q  <= '0;
         err_oob_q  <= 1'b0;
         wr_count_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         clr_ptr_q  <= clr_ptr_d;
         err_oob_q  <= err_oob_d;
         wr_count_q <= wr_count_d;
      end
   end

   assign dm_ready = is_ready;
   assign err_oob  = err_oob_q;
   assign wr_count = wr_count_q;

   // ------------------------------------------------------------------
   // Optional write trace
   // ------------------------------------------------------------------
`ifdef DM_TRACE_EN
   always_ff @(posedge clk) begin
      if (reset && wr_hit) begin
         $display("%d@%h: *%h <= %h", $time, m_inst_addr,
                  {m_data_addr[31:2], 2'b00}, merged_word);
      end
   end
`else
   // The PC only feeds the trace.
   logic unused_inst_addr;
   assign unused_inst_addr = ^m_inst_addr;
`endif

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

   localparam int DEPTH = 16;
   localparam int NRAND = 250;

   logic        clk;
   logic        reset;
   logic [31:0] m_data_addr;
   logic [31:0] m_data_wdata;
   logic [3:0]  m_data_byteen;
   logic [31:0] m_inst_addr;
   logic [31:0] m_data_rdata;
   logic        dm_ready;
   logic        err_oob;
   logic [31:0] wr_count;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] model_mem [DEPTH];
   logic [31:0] model_wr;
   logic        model_err;

   dm_responder #(.DEPTH(DEPTH), .BASE(32'h0000_0000)) dut (
      .clk           (clk),
      .reset         (reset),
      .m_data_addr   (m_data_addr),
      .m_data_wdata  (m_data_wdata),
      .m_data_byteen (m_data_byteen),
      .m_inst_addr   (m_inst_addr),
      .m_data_rdata  (m_data_rdata),
      .dm_ready      (dm_ready),
      .err_oob       (err_oob),
      .wr_count      (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] read_addr;
      logic [31:0] exp_word;
      logic [31:0] exp_wr;
   } vec_t;

   vec_t vecs [6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      m_data_addr   = a;
      m_data_wdata  = d;
      m_data_byteen = be;
      m_inst_addr   = 32'h0000_1000 + {a[29:0], 2'b00};
   endtask

   task automatic read_word(input logic [31:0] a, output logic [31:0] v);
      drive(a, 32'h0, 4'h0);
      #1;
      v = m_data_rdata;
   endtask

   // Hold reset low for three edges, release and count the clear edges.
   // Optionally throw CPU writes at the block while it is clearing.
   task automatic reset_and_clear(input bit inject);
      logic [31:0] rd;
      reset = 1'b0;
      drive(32'h0, 32'h0, 4'h0);
      repeat (3) tick();
      check("reset_ready", {31'h0, dm_ready}, 32'h0);
      check("reset_err", {31'h0, err_oob}, 32'h0);
      check("reset_wrcnt", wr_count, 32'h0);
      reset = 1'b1;
      for (int e = 1; e <= DEPTH; e++) begin
         if (inject && e >= 5 && e <= 10) drive(32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
         else if (inject && e == 11)      drive(32'h0000_0040, 32'h1234_5678, 4'hF);
         else                             drive(32'h0000_0004, 32'h0, 4'h0);
         if (inject && e == 8) begin
            #1;
            check("clear_rdata_zero", m_data_rdata, 32'h0);
         end
         tick();
         check($sformatf("ready_edge%0d", e), {31'h0, dm_ready}, (e == DEPTH) ? 32'h1 : 32'h0);
      end
      drive(32'h0, 32'h0, 4'h0);
      check("clear_wrcnt", wr_count, 32'h0);
      check("clear_err", {31'h0, err_oob}, 32'h0);
      for (int w = 0; w < DEPTH; w++) begin
         read_word(32'(w * 4), rd);
         check($sformatf("zero_word%0d", w), rd, 32'h0);
         model_mem[w] = 32'h0;
      end
      model_wr  = 32'h0;
      model_err = 1'b0;
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      logic [31:0] m;
      m = 32'h0;
      if (be[0]) m = m | 32'h0000_00FF;
      if (be[1]) m = m | 32'h0000_FF00;
      if (be[2]) m = m | 32'h00FF_0000;
      if (be[3]) m = m | 32'hFF00_0000;
      return m;
   endfunction

   initial begin
      logic [31:0] rd;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  be;
      logic [31:0] exp_rd;
      logic [31:0] mask;

      reset = 1'b0;
      drive(32'h0, 32'h0, 4'h0);

      vecs[0] = '{32'h0000_0008, 32'h1122_3344, 4'hF,    32'h0000_0008, 32'h1122_3344, 32'd1};
      vecs[1] = '{32'h0000_0008, 32'hAABB_CCDD, 4'b0101, 32'h0000_0008, 32'h11BB_33DD, 32'd2};
      vecs[2] = '{32'h0000_000B, 32'h5500_0000, 4'b1000, 32'h0000_0008, 32'h55BB_33DD, 32'd3};
      vecs[3] = '{32'h0000_000C, 32'h0000_0005, 4'hF,    32'h0000_000C, 32'h0000_0005, 32'd4};
      vecs[4] = '{32'h0000_003C, 32'hCAFE_F00D, 4'b0011, 32'h0000_003E, 32'h0000_F00D, 32'd5};
      vecs[5] = '{32'h0000_0000, 32'h1234_5678, 4'b0110, 32'h0000_0001, 32'h0034_5600, 32'd6};

      // Reset release with writes attempted during the clear sequence
      reset_and_clear(1'b1);

      // Table-driven writes and read-back
      for (int i = 0; i < 6; i++) begin
         drive(vecs[i].addr, vecs[i].wdata, vecs[i].be);
         tick();
         read_word(vecs[i].read_addr, rd);
         check($sformatf("vec%0d_word", i), rd, vecs[i].exp_word);
         check($sformatf("vec%0d_wrcnt", i), wr_count, vecs[i].exp_wr);
         check($sformatf("vec%0d_err", i), {31'h0, err_oob}, 32'h0);
      end

      // Read during write of the same word: old value now, new value next cycle
      drive(32'h0000_000C, 32'h0000_0009, 4'hF);
      #1;
      check("rdw_old", m_data_rdata, 32'h0000_0005);
      tick();
      read_word(32'h0000_000C, rd);
      check("rdw_new", rd, 32'h0000_0009);
      check("rdw_wrcnt", wr_count, 32'd7);

      // Out-of-range write: sticky error, memory and count unchanged
      drive(32'h0000_0040, 32'hFFFF_FFFF, 4'hF);
      #1;
      check("oob_not_yet", {31'h0, err_oob}, 32'h0);
      tick();
      check("oob_err", {31'h0, err_oob}, 32'h1);
      read_word(32'h0000_0040, rd);
      check("oob_read", rd, 32'h0);
      check("oob_wrcnt", wr_count, 32'd7);
      drive(32'hFFFF_FFFC, 32'h7777_7777, 4'hF);
      tick();
      drive(32'h0000_0000, 32'h0, 4'h0);
      repeat (3) tick();
      check("oob_sticky", {31'h0, err_oob}, 32'h1);
      check("oob_wrcnt2", wr_count, 32'd7);
      read_word(32'h0000_0000, rd);
      check("oob_mem_intact", rd, 32'h0034_5600);

      // Randomised traffic against the reference model, from a clean start
      reset_and_clear(1'b0);
      for (int n = 0; n < NRAND; n++) begin
         a  = $urandom_range(0, 32'h47);
         if ($urandom_range(0, 15) == 0) a = $urandom;
         d  = $urandom;
         be = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) be = 4'h0;
         drive(a, d, be);
         #1;
         exp_rd = (a < 32'(4 * DEPTH)) ? model_mem[a[5:2]] : 32'h0;
         check($sformatf("rand%0d_rdata", n), m_data_rdata, exp_rd);
         tick();
         if (be != 4'h0) begin
            if (a < 32'(4 * DEPTH)) begin
               mask = lane_mask(be);
               model_mem[a[5:2]] = (model_mem[a[5:2]] & ~mask) | (d & mask);
               model_wr = model_wr + 32'd1;
            end else begin
               model_err = 1'b1;
            end
         end
         check($sformatf("rand%0d_wrcnt", n), wr_count, model_wr);
         check($sformatf("rand%0d_err", n), {31'h0, err_oob}, {31'h0, model_err});
      end
      for (int w = 0; w < DEPTH; w++) begin
         read_word(32'(w * 4), rd);
         check($sformatf("rand_final_word%0d", w), rd, model_mem[w]);
      end

      // Reset in the middle of operation and again in the middle of clearing
      drive(32'h0000_003C, 32'hFFFF_FFFF, 4'hF);
      tick();
      read_word(32'h0000_003C, rd);
      check("pre_reset_word", rd, 32'hFFFF_FFFF);
      reset = 1'b0;
      #1;
      check("async_rst_ready", {31'h0, dm_ready}, 32'h0);
      check("async_rst_wrcnt", wr_count, 32'h0);
      tick();
      tick();
      reset = 1'b1;
      repeat (5) tick();
      read_word(32'h0000_003C, rd);
      check("midclear_rdata", rd, 32'h0);
      check("midclear_ready", {31'h0, dm_ready}, 32'h0);
      reset = 1'b0;
      tick();
      check("reclear_ready", {31'h0, dm_ready}, 32'h0);
      check("reclear_err", {31'h0, err_oob}, 32'h0);
      check("reclear_wrcnt", wr_count, 32'h0);
      reset = 1'b1;
      for (int e = 1; e <= DEPTH; e++) begin
         tick();
         check($sformatf("restart_edge%0d", e), {31'h0, dm_ready}, (e == DEPTH) ? 32'h1 : 32'h0);
      end
      for (int w = 0; w < DEPTH; w++) begin
         read_word(32'(w * 4), rd);
         check($sformatf("restart_word%0d", w), rd, 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
